// File: rtl/mux_rr_n_1_pkg.sv
// mux_pkg: mode encodings and index-width helper for mux_rr_n_1
package mux_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux_rr_n_1_rr_pick_n.sv
// rr_pick_n: rotating-priority search, first set req after base, wrapping mod N
module rr_pick_n
  import mux_pkg::*;
#(
  parameter int N = 16,
  localparam int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int c;
      c = int'(base) + k;
      c = (c >= N) ? c - N : c;
      if (req[c]) begin
        idx = SEL_W'(c);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_n_1.sv
// mux_rr_n_1: registered N:1 mux with valid/ready, directed or round-robin grant
module mux_rr_n_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 16,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   select,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int NP = 1 << SEL_W;
  logic [NP-1:0] vld_x;
  logic [SEL_W-1:0] rr_idx, grant, ptr_q, ptr_d, out_chan_q, out_chan_d;
  logic rr_found, dir_ok, granted, load, xfer, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  rr_pick_n #(.N(N)) u_pick (
    .req  (in_valid),
    .base (ptr_q),
    .idx  (rr_idx),
    .found(rr_found)
  );
  always_comb begin
    vld_x = NP'(in_valid);
    dir_ok = (int'(select) < N) & vld_x[select];
    granted = (mode == MODE_RR) ? rr_found : dir_ok;
    grant = (mode == MODE_RR) ? rr_idx : select;
    load = out_ready | ~out_valid_q;
    xfer = load & granted;
    in_ready = (rst_n & xfer) ? N'(1) << grant : '0;
    out_valid_d = load ? granted : out_valid_q;
    out_data_d = xfer ? in_data[int'(grant)*WIDTH +: WIDTH] : out_data_q;
    out_chan_d = xfer ? grant : out_chan_q;
    ptr_d = xfer ? grant : ptr_q;
  end
  // ptr resets to N-1 so the first round-robin scan begins at channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
endmodule
